// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiplier and restoring divider, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN ends multiplies once the remaining multiplier bits are all zero.
module muldiv_sequencer #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [1:0]      state_dbg_o
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d;
   logic [XLEN-1:0]   mplier_q, mplier_d, result_q, result_d;

   logic              a_signed, b_signed, a_neg, b_neg, b_zero, div_ovf, special;
   logic [XLEN-1:0]   a_mag, b_mag, special_res;

   // Operand decode: magnitudes, signs and the ops that finish without iterating.
   always_comb begin
      a_signed    = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
      b_signed    = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
      a_neg       = a_signed & a_i[XLEN-1];
      b_neg       = b_signed & b_i[XLEN-1];
      a_mag       = a_neg ? -a_i : a_i;
      b_mag       = b_neg ? -b_i : b_i;
      b_zero      = (b_i == '0);
      div_ovf     = op_i[2] & ~op_i[0] & (a_i == INT_MIN) & (b_i == '1);
      special     = 1'b0;
      special_res = '0;
      if (op_i[2] && b_zero) begin
         special     = 1'b1;
         special_res = op_i[1] ? a_i : '1;
      end else if (div_ovf) begin
         special     = 1'b1;
         special_res = op_i[1] ? '0 : INT_MIN;
      end
`ifdef MULDIV_EARLY_OUT_EN
      else if (!op_i[2] && b_zero) begin
         special     = 1'b1;
         special_res = '0;
      end
`endif
   end

   logic [XLEN:0]     div_top, div_diff;
   logic [2*XLEN-1:0] acc_step;
   logic [XLEN-1:0]   mulh_res, quo_res, rem_res, final_res;
   logic              last_iter;

   // One iteration; for divide acc holds {remainder, dividend/quotient}.
   always_comb begin
      div_top  = acc_q[2*XLEN-1:XLEN-1];
      div_diff = div_top - {1'b0, mcand_q[XLEN-1:0]};
      if (op_q[2]) begin
         acc_step = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
      end
      // High half of the negated product: invert, carry in only when the low half is zero.
      mulh_res = neg_q ? (~acc_step[2*XLEN-1:XLEN] + XLEN'(acc_step[XLEN-1:0] == '0))
                       : acc_step[2*XLEN-1:XLEN];
      quo_res  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      rem_res  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
      case (op_q)
         3'd0:             final_res = acc_step[XLEN-1:0];
         3'd1, 3'd2, 3'd3: final_res = mulh_res;
         3'd4, 3'd5:       final_res = quo_res;
         default:          final_res = rem_res;
      endcase
      last_iter = (cnt_q == CNT_W'(XLEN-1));
`ifdef MULDIV_EARLY_OUT_EN
      if (!op_q[2] && (mplier_q[XLEN-1:1] == '0)) last_iter = 1'b1;
`endif
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      result_d = result_q;
      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  op_d     = op_i;
                  neg_d    = (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);
                  cnt_d    = '0;
                  mplier_d = b_mag;
                  if (op_i[2]) begin
                     acc_d   = {{XLEN{1'b0}}, a_mag};
                     mcand_d = {{XLEN{1'b0}}, b_mag};
                  end else begin
                     acc_d   = '0;
                     mcand_d = {{XLEN{1'b0}}, a_mag};
                  end
                  if (special) begin
                     result_d = special_res;
                     state_d  = S_DONE;
                  end else begin
                     state_d  = S_RUN;
                  end
               end
            end
            S_RUN: begin
               acc_d = acc_step;
               cnt_d = cnt_q + CNT_W'(1);
               if (!op_q[2]) begin
                  mcand_d  = mcand_q << 1;
                  mplier_d = mplier_q >> 1;
               end
               if (last_iter) begin
                  result_d = final_res;
                  state_d  = S_DONE;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         result_q <= result_d;
      end
   end

   assign done_o      = (state_q == S_DONE) & ~flush_i;
   assign stall_o     = start_i & ~done_o;
   assign busy_o      = (state_q != S_IDLE);
   assign result_o    = result_q;
   assign state_dbg_o = state_q;
endmodule
